// File: rtl/rv32i_decode_pkg.sv
// Shared constants and bundle type for the RV32I decode stage.
package rv32i_decode_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 37;
  localparam int unsigned CNT_W = 32;

  // Bit positions inside the one-hot operation vector
  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_XOR   = 2;
  localparam int unsigned OP_OR    = 3;
  localparam int unsigned OP_AND   = 4;
  localparam int unsigned OP_SLL   = 5;
  localparam int unsigned OP_SRL   = 6;
  localparam int unsigned OP_SRA   = 7;
  localparam int unsigned OP_SLT   = 8;
  localparam int unsigned OP_SLTU  = 9;
  localparam int unsigned OP_ADDI  = 10;
  localparam int unsigned OP_XORI  = 11;
  localparam int unsigned OP_ORI   = 12;
  localparam int unsigned OP_ANDI  = 13;
  localparam int unsigned OP_SLLI  = 14;
  localparam int unsigned OP_SRLI  = 15;
  localparam int unsigned OP_SLTI  = 16;
  localparam int unsigned OP_LB    = 17;
  localparam int unsigned OP_LH    = 18;
  localparam int unsigned OP_LW    = 19;
  localparam int unsigned OP_LBU   = 20;
  localparam int unsigned OP_LHU   = 21;
  localparam int unsigned OP_SB    = 22;
  localparam int unsigned OP_SH    = 23;
  localparam int unsigned OP_SW    = 24;
  localparam int unsigned OP_SRAI  = 25;
  localparam int unsigned OP_SLTIU = 26;
  localparam int unsigned OP_BEQ   = 27;
  localparam int unsigned OP_BNE   = 28;
  localparam int unsigned OP_BLT   = 29;
  localparam int unsigned OP_BGE   = 30;
  localparam int unsigned OP_BLTU  = 31;
  localparam int unsigned OP_BGEU  = 32;
  localparam int unsigned OP_LUI   = 33;
  localparam int unsigned OP_JAL   = 34;
  localparam int unsigned OP_JALR  = 35;
  localparam int unsigned OP_AUIPC = 36;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] imm;
    logic            imm_valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } dec_bundle_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate extraction for RV32I I/S/B/U/J formats; shift-immediates are zero-extended shamt.
module rv32i_imm_gen
  import rv32i_decode_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic            imm_valid
);

  always_comb begin
    imm       = '0;
    imm_valid = 1'b0;
    case (instr[6:0])
      OPC_OPIMM: begin
        imm_valid = 1'b1;
        // funct3 001/101 are the shift forms
        if (instr[13:12] == 2'b01) imm = XLEN'(instr[24:20]);
        else                       imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LOAD, OPC_JALR: begin
        imm_valid = 1'b1;
        imm       = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        imm_valid = 1'b1;
        imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        imm_valid = 1'b1;
        imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_valid = 1'b1;
        imm       = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        imm_valid = 1'b1;
        imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides and a one-entry skid buffer.
module rv32i_decode_stage
  import rv32i_decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_imm_valid,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic              out_rd_we,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  decoded_count
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [OP_W-1:0] dec_op;
  logic            rd_class;
  logic            dec_illegal;
  logic [XLEN-1:0] imm_c;
  logic            imm_valid_c;
  dec_bundle_t     dec_c;

  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  dec_bundle_t     out_q, out_d;
  dec_bundle_t     skid_q, skid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic            accept;
  logic            drain;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  rv32i_imm_gen u_imm_gen (
    .instr     (in_instr),
    .imm       (imm_c),
    .imm_valid (imm_valid_c)
  );

  // One-hot operation decode; an empty vector marks an illegal encoding
  always_comb begin
    dec_op   = '0;
    rd_class = 1'b0;
    case (opc)
      OPC_OP: begin
        rd_class = 1'b1;
        case ({f7, f3})
          {F7_BASE, 3'b000}: dec_op[OP_ADD]  = 1'b1;
          {F7_ALT,  3'b000}: dec_op[OP_SUB]  = 1'b1;
          {F7_BASE, 3'b001}: dec_op[OP_SLL]  = 1'b1;
          {F7_BASE, 3'b010}: dec_op[OP_SLT]  = 1'b1;
          {F7_BASE, 3'b011}: dec_op[OP_SLTU] = 1'b1;
          {F7_BASE, 3'b100}: dec_op[OP_XOR]  = 1'b1;
          {F7_BASE, 3'b101}: dec_op[OP_SRL]  = 1'b1;
          {F7_ALT,  3'b101}: dec_op[OP_SRA]  = 1'b1;
          {F7_BASE, 3'b110}: dec_op[OP_OR]   = 1'b1;
          {F7_BASE, 3'b111}: dec_op[OP_AND]  = 1'b1;
          default: ;
        endcase
      end
      OPC_OPIMM: begin
        rd_class = 1'b1;
        case (f3)
          3'b000: dec_op[OP_ADDI]  = 1'b1;
          3'b010: dec_op[OP_SLTI]  = 1'b1;
          3'b011: dec_op[OP_SLTIU] = 1'b1;
          3'b100: dec_op[OP_XORI]  = 1'b1;
          3'b110: dec_op[OP_ORI]   = 1'b1;
          3'b111: dec_op[OP_ANDI]  = 1'b1;
          3'b001: if (f7 == F7_BASE) dec_op[OP_SLLI] = 1'b1;
          3'b101: begin
            if (f7 == F7_BASE)     dec_op[OP_SRLI] = 1'b1;
            else if (f7 == F7_ALT) dec_op[OP_SRAI] = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_LOAD: begin
        rd_class = 1'b1;
        case (f3)
          3'b000: dec_op[OP_LB]  = 1'b1;
          3'b001: dec_op[OP_LH]  = 1'b1;
          3'b010: dec_op[OP_LW]  = 1'b1;
          3'b100: dec_op[OP_LBU] = 1'b1;
          3'b101: dec_op[OP_LHU] = 1'b1;
          default: ;
        endcase
      end
      OPC_STORE: begin
        case (f3)
          3'b000: dec_op[OP_SB] = 1'b1;
          3'b001: dec_op[OP_SH] = 1'b1;
          3'b010: dec_op[OP_SW] = 1'b1;
          default: ;
        endcase
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000: dec_op[OP_BEQ]  = 1'b1;
          3'b001: dec_op[OP_BNE]  = 1'b1;
          3'b100: dec_op[OP_BLT]  = 1'b1;
          3'b101: dec_op[OP_BGE]  = 1'b1;
          3'b110: dec_op[OP_BLTU] = 1'b1;
          3'b111: dec_op[OP_BGEU] = 1'b1;
          default: ;
        endcase
      end
      OPC_LUI: begin
        rd_class           = 1'b1;
        dec_op[OP_LUI]     = 1'b1;
      end
      OPC_AUIPC: begin
        rd_class           = 1'b1;
        dec_op[OP_AUIPC]   = 1'b1;
      end
      OPC_JAL: begin
        rd_class           = 1'b1;
        dec_op[OP_JAL]     = 1'b1;
      end
      OPC_JALR: begin
        rd_class = 1'b1;
        if (f3 == 3'b000) dec_op[OP_JALR] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dec_illegal     = ~|dec_op;
    dec_c           = '0;
    dec_c.op        = dec_op;
    dec_c.imm       = imm_c;
    dec_c.imm_valid = imm_valid_c & ~dec_illegal;
    dec_c.rs1       = in_instr[19:15];
    dec_c.rs2       = in_instr[24:20];
    dec_c.rd        = in_instr[11:7];
    dec_c.rd_we     = rd_class & ~dec_illegal & (|in_instr[11:7]);
    dec_c.pc        = in_pc;
    dec_c.illegal   = dec_illegal;
  end

  // Output register / skid buffer next state; flush wins over accept and drain
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    count_d      = count_q;
    accept       = in_valid & in_ready_q;
    drain        = out_valid_q & out_ready;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (drain) count_d = count_q + CNT_W'(1);
      if (!out_valid_q || out_ready) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_d        = skid_q;
          skid_valid_d = accept;
          if (accept) skid_d = dec_c;
        end else begin
          out_valid_d = accept;
          if (accept) out_d = dec_c;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_d       = dec_c;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
      count_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      count_q      <= count_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_op        = out_q.op;
  assign out_imm       = out_q.imm;
  assign out_imm_valid = out_q.imm_valid;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_rd_we     = out_q.rd_we;
  assign out_pc        = out_q.pc;
  assign out_illegal   = out_q.illegal;
  assign decoded_count = count_q;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed scenarios plus random traffic against a table-driven reference.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc, decoded_count;
  logic [36:0] out_op;
  logic        out_imm_valid, out_rd_we, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32i_decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
    .out_imm_valid(out_imm_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_pc(out_pc), .out_illegal(out_illegal),
    .decoded_count(decoded_count)
  );

  typedef struct {
    logic [36:0] op;
    logic [31:0] imm;
    logic        imm_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  // Legal encodings, listed in operation-bit order; -1 means "don't care"
  int t_opc[37] = '{'h33,'h33,'h33,'h33,'h33,'h33,'h33,'h33,'h33,'h33,
                    'h13,'h13,'h13,'h13,'h13,'h13,'h13,
                    'h03,'h03,'h03,'h03,'h03, 'h23,'h23,'h23, 'h13,'h13,
                    'h63,'h63,'h63,'h63,'h63,'h63, 'h37,'h6F,'h67,'h17};
  int t_f3[37]  = '{0,0,4,6,7,1,5,5,2,3, 0,4,6,7,1,5,2, 0,1,2,4,5, 0,1,2, 5,3,
                    0,1,4,5,6,7, -1,-1,0,-1};
  int t_f7[37]  = '{0,32,0,0,0,0,0,32,0,0, -1,-1,-1,-1,0,0,-1, -1,-1,-1,-1,-1, -1,-1,-1, 32,-1,
                    -1,-1,-1,-1,-1,-1, -1,-1,-1,-1};

  exp_t        q[$];
  int unsigned m_count;
  logic        m_in_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   idx = -1;
    int   v   = 0;
    for (int k = 0; k < 37; k++)
      if (int'(w[6:0]) == t_opc[k] && (t_f3[k] < 0 || int'(w[14:12]) == t_f3[k]) &&
          (t_f7[k] < 0 || int'(w[31:25]) == t_f7[k]))
        idx = k;
    e.op = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.pc  = pc;
    e.illegal   = (idx < 0);
    e.imm_valid = (idx >= 10);
    e.rd_we     = (idx >= 0) && !(idx >= 22 && idx <= 24) && !(idx >= 27 && idx <= 32) && (w[11:7] != 5'd0);
    if (idx >= 0) e.op[idx] = 1'b1;
    if (idx == 14 || idx == 15 || idx == 25)
      v = int'(w[24:20]);
    else if ((idx >= 10 && idx <= 21) || idx == 26 || idx == 35)
      v = $signed(w) >>> 20;
    else if (idx >= 22 && idx <= 24)
      v = (w[31] ? -2048 : 0) + 32 * int'(w[30:25]) + int'(w[11:7]);
    else if (idx >= 27 && idx <= 32)
      v = (w[31] ? -4096 : 0) + 2048 * int'(w[7]) + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
    else if (idx == 33 || idx == 36)
      v = int'(w & 32'hFFFFF000);
    else if (idx == 34)
      v = (w[31] ? -(1 << 20) : 0) + 4096 * int'(w[19:12]) + 2048 * int'(w[20]) + 2 * int'(w[30:21]);
    e.imm = 32'(v);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    if ($urandom_range(0, 4) == 0) return w;
    k = $urandom_range(0, 36);
    w[6:0] = 7'(t_opc[k]);
    if (t_f3[k] >= 0) w[14:12] = 3'(t_f3[k]);
    if (t_f7[k] >= 0) w[31:25] = 7'(t_f7[k]);
    return w;
  endfunction

  task automatic compare();
    check_eq("in_ready", in_ready, m_in_ready);
    check_eq("out_valid", out_valid, q.size() != 0);
    check_eq("decoded_count", decoded_count, m_count);
    if (q.size() != 0) begin
      check_eq("out_op", out_op, q[0].op);
      check_eq("out_illegal", out_illegal, q[0].illegal);
      check_eq("out_imm_valid", out_imm_valid, q[0].imm_valid);
      check_eq("out_rd_we", out_rd_we, q[0].rd_we);
      check_eq("out_rs1", out_rs1, q[0].rs1);
      check_eq("out_rs2", out_rs2, q[0].rs2);
      check_eq("out_rd", out_rd, q[0].rd);
      check_eq("out_pc", out_pc, q[0].pc);
      if (q[0].imm_valid) check_eq("out_imm", out_imm, q[0].imm);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check at the falling edge
  task automatic step(input logic rst, input logic fl, input logic iv, input logic [31:0] ins,
                      input logic [31:0] p, input logic ordy);
    logic acc;
    reset = rst; flush = fl; in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy;
    @(posedge clk);
    acc = iv && m_in_ready;
    if (rst) begin
      q.delete(); m_count = 0; m_in_ready = 1'b0;
    end else if (fl) begin
      q.delete(); m_in_ready = 1'b1;
    end else begin
      if (q.size() != 0 && ordy) begin
        void'(q.pop_front());
        m_count++;
      end
      if (acc) q.push_back(ref_decode(ins, p));
      m_in_ready = (q.size() < 2);
    end
    @(negedge clk);
    compare();
  endtask

  task automatic check_reset_zero();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_op", out_op, 0);
    check_eq("rst_out_imm", out_imm, 0);
    check_eq("rst_fields", {out_imm_valid, out_rs1, out_rs2, out_rd, out_rd_we, out_illegal}, 0);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_count", decoded_count, 0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'hFFF00293;
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3;

  initial begin
    logic [31:0] seen[$];
    logic        sent;
    m_count = 0; m_in_ready = 1'b0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_reset_zero();
    step(0, 0, 0, 0, 0, 1);
    check_eq("in_ready_after_reset", in_ready, 1);

    // ADD x3,x1,x2
    step(0, 0, 1, I_ADD, 32'h100, 1);
    check_eq("add_op", out_op, 37'h1);
    check_eq("add_regs", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd3});
    check_eq("add_rd_we", out_rd_we, 1);
    check_eq("add_imm_valid", out_imm_valid, 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("add_count", decoded_count, 1);

    // ADDI x5,x0,-1 then BEQ x1,x2,-8
    step(0, 0, 1, I_ADDI, 32'h104, 1);
    check_eq("addi_op", out_op, 37'h1 << 10);
    check_eq("addi_imm", out_imm, 32'hFFFFFFFF);
    check_eq("addi_imm_valid", out_imm_valid, 1);
    check_eq("addi_rd_we", out_rd_we, 1);
    step(0, 0, 1, I_BEQ, 32'h108, 1);
    check_eq("beq_op", out_op, 37'h1 << 27);
    check_eq("beq_imm", out_imm, 32'hFFFFFFF8);
    check_eq("beq_rd_we", out_rd_we, 0);
    step(0, 0, 0, 0, 0, 1);

    // Backpressure through the skid buffer
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, I_ADD, 32'h0, 0);
    step(0, 0, 1, I_ADD, 32'h4, 0);
    check_eq("bp_in_ready_low", in_ready, 0);
    step(0, 0, 1, I_ADD, 32'h8, 0);
    check_eq("bp_held_pc", out_pc, 32'h0);
    sent = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic take;
      if (out_valid) seen.push_back(out_pc);
      take = !sent && in_ready;
      step(0, 0, !sent, I_ADD, 32'h8, 1);
      if (take) sent = 1'b1;
    end
    check_eq("bp_seen_n", seen.size(), 3);
    if (seen.size() == 3) begin
      check_eq("bp_order0", seen[0], 32'h0);
      check_eq("bp_order1", seen[1], 32'h4);
      check_eq("bp_order2", seen[2], 32'h8);
    end
    check_eq("bp_count", decoded_count, 3);

    // Illegal encodings followed by a legal one
    step(0, 0, 1, 32'h00000000, 32'h200, 1);
    check_eq("ill0_flag", out_illegal, 1);
    check_eq("ill0_op", out_op, 0);
    check_eq("ill0_rd_we", out_rd_we, 0);
    step(0, 0, 1, 32'h40007033, 32'h204, 1);
    check_eq("ill1_flag", out_illegal, 1);
    check_eq("ill1_op", out_op, 0);
    check_eq("ill1_rd_we", out_rd_we, 0);
    step(0, 0, 1, I_ADD, 32'h208, 1);
    check_eq("post_ill_op", out_op, 37'h1);
    check_eq("post_ill_flag", out_illegal, 0);
    step(0, 0, 0, 0, 0, 1);

    // Flush with output and skid full and a new offer
    step(0, 0, 1, I_ADDI, 32'h300, 0);
    step(0, 0, 1, I_BEQ, 32'h304, 0);
    check_eq("fl_pre_in_ready", in_ready, 0);
    begin
      logic [31:0] cnt_before;
      cnt_before = decoded_count;
      step(0, 1, 1, I_ADD, 32'h308, 0);
      check_eq("fl_out_valid", out_valid, 0);
      check_eq("fl_in_ready", in_ready, 1);
      check_eq("fl_count", decoded_count, cnt_before);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

    // Reset mid-stream while holding a bundle
    step(0, 0, 1, I_ADD, 32'h400, 0);
    check_eq("mid_out_valid", out_valid, 1);
    step(1, 0, 1, I_ADD, 32'h404, 0);
    check_reset_zero();
    step(0, 0, 0, 0, 0, 0);
    check_eq("mid_in_ready", in_ready, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 9) < 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Registered RV32I decode stage that produces the one-hot operation vector, immediate and register fields consumed by the execute-stage ALU.
- Sits between instruction fetch and execute.
- Uses valid/ready handshakes on both sides, with a one-entry skid buffer so that `in_ready` is driven directly from a flop.
- Provides a flush input for taken branches and jumps, and a decoded-instruction counter for debug.

Parameters:
- XLEN, 32, data/PC width.
- OP_W, 37, width of the one-hot operation vector.
- CNT_W, 32, width of the decoded-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- flush  input  1  discard all held and in-flight instructions.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  PC of `in_instr`.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts the bundle.
- out_op  output  OP_W  one-hot operation; all zero if illegal.
- out_imm  output  XLEN  sign-extended immediate.
- out_imm_valid  output  1  the operation uses `out_imm`.
- out_rs1  output  5  source register 1 index.
- out_rs2  output  5  source register 2 index.
- out_rd  output  5  destination register index.
- out_rd_we  output  1  register-file write enable.
- out_pc  output  XLEN  PC of the bundle.
- out_illegal  output  1  unsupported encoding.
- decoded_count  output  CNT_W  number of bundles accepted by execute.

Behaviour:
- **Reset.** While `reset` is high at a clock edge:
  - `out_valid` = 0, `in_ready` = 0, skid buffer empty, `decoded_count` = 0.
  - All other outputs = 0.
  - `in_ready` becomes 1 on the first edge after reset is released.
- **Handshakes.**
  - Input transfer occurs on `in_valid & in_ready`; output transfer occurs on `out_valid & out_ready`.
  - The output register holds every field stable while `out_valid & !out_ready`.
- **Latency.** An instruction accepted at edge N appears on the outputs after edge N, i.e. one cycle, when the output register is free or draining.
- **Skid buffer.**
  - If an instruction is accepted while the output register is full and not draining, the decoded bundle goes to the skid buffer and `in_ready` drops on the next edge.
  - When the output drains, the skid buffer moves into the output register and `in_ready` rises on the next edge.
  - Order is strictly preserved and no bundle is ever dropped or duplicated.
- **Throughput.** One instruction per cycle when `out_ready` = 1.
- **Flush.**
  - At an edge with `flush` = 1: `out_valid` = 0, the skid buffer is emptied, any input offered that cycle is discarded, and `in_ready` = 1 next cycle.
  - `flush` takes precedence over accept and drain.
  - `reset` takes precedence over `flush`.
- **Decode encoding.** `out_op` bit indices are defined in the shared package:

  | Bits | Operations |
  |---|---|
  | 0-9 | ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU |
  | 10-16 | ADDI, XORI, ORI, ANDI, SLLI, SRLI, SLTI |
  | 17-21 | LB, LH, LW, LBU, LHU |
  | 22-24 | SB, SH, SW |
  | 25-26 | SRAI, SLTIU |
  | 27-32 | BEQ, BNE, BLT, BGE, BLTU, BGEU |
  | 33-36 | LUI, JAL, JALR, AUIPC |

  Exactly one bit is set for a legal instruction.
- **Immediates.**
  - Formats I/S/B/U/J follow the RV32I spec and are sign-extended from `instr[31]`.
  - SLLI/SRLI/SRAI: `out_imm` = zero-extended shamt `instr[24:20]`.
  - `out_imm_valid` = 1 for all I, S, B, U and J forms; 0 for R-type.
- **Register fields.**
  - `out_rs1` = `instr[19:15]`, `out_rs2` = `instr[24:20]`, `out_rd` = `instr[11:7]`, passed through raw.
  - `out_rd_we` = 1 only for R, I-ALU, load, LUI, AUIPC, JAL and JALR with `rd` != 0.
- **Illegal encodings.**
  - Any unknown opcode/funct3/funct7 is illegal, e.g. funct7 not in {0000000, 0100000}, or 0100000 on anything other than SUB/SRA/SRAI.
  - An illegal instruction produces `out_op` = 0, `out_illegal` = 1, `out_rd_we` = 0, `out_imm_valid` = 0.
  - It still passes through the handshake like any other bundle.
- **Counter.** `decoded_count` increments by 1 on each output transfer (illegal bundles included) and wraps modulo 2^CNT_W.

Decomposition:
- Shared package `rv32i_decode_pkg`:
  - `out_op` bit-index localparams (`OP_ADD` = 0 … `OP_AUIPC` = 36) and OP_W.
  - Opcode constants (`OPC_OP` = 0110011, `OPC_OPIMM` = 0010011, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`).
  - funct7 constants.
- One combinational sub-module, `rv32i_imm_gen`: input `instr`, outputs `imm` and `imm_valid`.
- Decode logic, skid buffer and counter live in the top module.

Test Plan:
1. `0x002081B3` (ADD x3,x1,x2), `out_ready` = 1 → next cycle `out_op` = 0x1, rs1 = 1, rs2 = 2, rd = 3, `rd_we` = 1, `imm_valid` = 0, `decoded_count` = 1 after the transfer.
2. `0xFFF00293` (ADDI x5,x0,-1) → `out_op` = 1<<10, `out_imm` = 0xFFFFFFFF, `imm_valid` = 1, `rd_we` = 1; `0xFE208CE3` (BEQ x1,x2,-8) → `out_op` = 1<<27, `out_imm` = 0xFFFFFFF8, `rd_we` = 0.
3. Backpressure: `out_ready` = 0, offer PCs 0x0, 0x4, 0x8 back-to-back → first two accepted, `in_ready` = 0 from cycle 2; raise `out_ready` → bundles emerge in order 0x0, 0x4, 0x8 with no loss, `decoded_count` = 3.
4. Illegal: `0x00000000` and `0x40007033` (AND with funct7 0100000) → `out_illegal` = 1, `out_op` = 0, `rd_we` = 0; the following legal instruction decodes normally.
5. Flush with output and skid both full and `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1, no stale bundle ever appears; `decoded_count` is unchanged.
6. Assert `reset` mid-stream with `out_valid` = 1 → after the edge all outputs = 0 and `decoded_count` = 0; `in_ready` = 1 one cycle after `reset` falls.
